relax_osc_trim_ctrl: RTL and testbench

Multi-channel digital calibration controller for on-chip relaxation oscillators. Each channel's oscillator output is counted against a programmable gate window of `clk` cycles. The channel's trim code is then set by successive approximation (SAR) so its edge count matches a target. An optional tracking mode keeps each channel locked afterwards with ±1 LSB corrections. The block sits in the digital half of the oscillator macro and drives the analog trim DACs directly.

---
 rtl/relax_osc_trim_ctrl.sv | 231 +++++++++++++++++++++++
 tb/tb_relax_osc_trim_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/relax_osc_trim_ctrl.sv
// Multi-channel relaxation-oscillator calibration: edge counting over a gate window,
// SAR trim search per channel, and optional +/-1 LSB tracking once calibrated.
module relax_osc_trim_ctrl #(
    parameter int N_CH       = 2,
    parameter int CNT_W      = 12,
    parameter int TRIM_W     = 5,
    parameter int GATE_W     = 16,
    parameter int SETTLE_CYC = 8,
    parameter int LOCK_TOL   = 1,
    localparam int CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_CH-1:0]          osc_in,
    input  logic                     start,
    input  logic                     track_en,
    input  logic [CNT_W-1:0]         target,
    input  logic [GATE_W-1:0]        gate_len,
    output logic [N_CH*TRIM_W-1:0]   trim,
    output logic                     busy,
    output logic                     done,
    output logic [N_CH-1:0]          lock,
    output logic [CNT_W-1:0]         meas_cnt,
    output logic [CH_W-1:0]          meas_ch
);

    localparam int BIT_W = $clog2(TRIM_W + 1);
    localparam int SET_W = $clog2(SETTLE_CYC + 1);
    localparam int CYC_W = (GATE_W > SET_W) ? GATE_W : SET_W;
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
    localparam logic [TRIM_W-1:0] TRIM_MAX = '1;
    localparam logic [TRIM_W-1:0] TRIM_MID = TRIM_W'(1) << (TRIM_W - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_MEASURE,
        ST_DECIDE,
        ST_TRACK
    } state_t;

    state_t               state_r;
    logic [N_CH-1:0]      sync1_r, sync2_r, prev_r;
    logic [N_CH-1:0]      edge_s;
    logic [TRIM_W-1:0]    trim_r [N_CH];
    logic [CH_W-1:0]      ch_r, ch_next_s;
    logic [BIT_W-1:0]     sar_bit_r;
    logic                 sar_final_r;
    logic                 track_mode_r;
    logic [CYC_W-1:0]     cyc_cnt_r;
    logic [GATE_W-1:0]    gate_r;
    logic [CNT_W-1:0]     edge_cnt_r;
    logic                 busy_r, done_r;
    logic [N_CH-1:0]      lock_r;
    logic [CNT_W-1:0]     meas_cnt_r;
    logic [CH_W-1:0]      meas_ch_r;

    logic                 start_go_s;
    logic [TRIM_W-1:0]    cur_code_s, sar_code_s, trk_code_s, bit_mask_s;
    logic [CNT_W:0]       tgt_ext_s, tol_ext_s, lo_s, hi_sum_s, hi_s, cnt_ext_s;
    logic                 above_s, below_s, in_tol_s;

    // Two-flop synchronizer plus one delay stage for rising-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= '0;
            sync2_r <= '0;
            prev_r  <= '0;
        end else begin
            sync1_r <= osc_in;
            sync2_r <= sync1_r;
            prev_r  <= sync2_r;
        end
    end

    assign edge_s = sync2_r & ~prev_r;

    // Lock window: target -/+ tolerance, clamped to the counter range.
    always_comb begin
        tgt_ext_s = {1'b0, target};
        tol_ext_s = (CNT_W + 1)'(LOCK_TOL);
        cnt_ext_s = {1'b0, edge_cnt_r};
        lo_s      = (tgt_ext_s >= tol_ext_s) ? (tgt_ext_s - tol_ext_s) : '0;
        hi_sum_s  = tgt_ext_s + tol_ext_s;
        hi_s      = (hi_sum_s > {1'b0, CNT_MAX}) ? {1'b0, CNT_MAX} : hi_sum_s;
        above_s   = cnt_ext_s > hi_s;
        below_s   = cnt_ext_s < lo_s;
        in_tol_s  = !above_s && !below_s;
    end

    // Next trim code for the SAR step and for a tracking correction.
    always_comb begin
        cur_code_s = trim_r[ch_r];
        bit_mask_s = TRIM_W'(1) << sar_bit_r;
        // Resolve the current trial bit and arm the next lower one in the same update.
        sar_code_s = ((edge_cnt_r > target) ? (cur_code_s & ~bit_mask_s) : cur_code_s)
                     | (bit_mask_s >> 1);
        if (above_s && (cur_code_s != '0)) begin
            trk_code_s = cur_code_s - TRIM_W'(1);
        end else if (below_s && (cur_code_s != TRIM_MAX)) begin
            trk_code_s = cur_code_s + TRIM_W'(1);
        end else begin
            trk_code_s = cur_code_s;
        end
        ch_next_s  = (ch_r == CH_W'(N_CH - 1)) ? '0 : (ch_r + CH_W'(1));
        start_go_s = start && !busy_r && ((state_r == ST_IDLE) || track_mode_r);
    end

    // Flatten per-channel trim registers onto the output bus.
    always_comb begin
        trim = '0;
        for (int c = 0; c < N_CH; c++) begin
            trim[c*TRIM_W +: TRIM_W] = trim_r[c];
        end
    end

    // Calibration / tracking sequencer with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            for (int c = 0; c < N_CH; c++) begin
                trim_r[c] <= TRIM_MID;
            end
            ch_r         <= '0;
            sar_bit_r    <= '0;
            sar_final_r  <= 1'b0;
            track_mode_r <= 1'b0;
            cyc_cnt_r    <= '0;
            gate_r       <= '0;
            edge_cnt_r   <= '0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            lock_r       <= '0;
            meas_cnt_r   <= '0;
            meas_ch_r    <= '0;
        end else begin
            done_r <= 1'b0;
            if (start_go_s) begin
                busy_r       <= 1'b1;
                lock_r       <= '0;
                track_mode_r <= 1'b0;
                ch_r         <= '0;
                sar_bit_r    <= BIT_W'(TRIM_W - 1);
                sar_final_r  <= 1'b0;
                trim_r[0]    <= TRIM_MID;
                cyc_cnt_r    <= '0;
                state_r      <= ST_SETTLE;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        state_r <= ST_IDLE;
                    end
                    ST_TRACK: begin
                        cyc_cnt_r <= '0;
                        state_r   <= ST_SETTLE;
                    end
                    ST_SETTLE: begin
                        if (cyc_cnt_r == CYC_W'(SETTLE_CYC - 1)) begin
                            cyc_cnt_r  <= '0;
                            gate_r     <= (gate_len == '0) ? GATE_W'(1) : gate_len;
                            edge_cnt_r <= '0;
                            state_r    <= ST_MEASURE;
                        end else begin
                            cyc_cnt_r <= cyc_cnt_r + CYC_W'(1);
                        end
                    end
                    ST_MEASURE: begin
                        if (edge_s[ch_r] && (edge_cnt_r != CNT_MAX)) begin
                            edge_cnt_r <= edge_cnt_r + CNT_W'(1);
                        end
                        if (cyc_cnt_r == CYC_W'(gate_r - GATE_W'(1))) begin
                            cyc_cnt_r <= '0;
                            state_r   <= ST_DECIDE;
                        end else begin
                            cyc_cnt_r <= cyc_cnt_r + CYC_W'(1);
                        end
                    end
                    ST_DECIDE: begin
                        meas_cnt_r <= edge_cnt_r;
                        meas_ch_r  <= ch_r;
                        cyc_cnt_r  <= '0;
                        if (track_mode_r) begin
                            trim_r[ch_r] <= trk_code_s;
                            lock_r[ch_r] <= in_tol_s;
                            if (track_en) begin
                                ch_r    <= ch_next_s;
                                state_r <= ST_TRACK;
                            end else begin
                                track_mode_r <= 1'b0;
                                state_r      <= ST_IDLE;
                            end
                        end else if (!sar_final_r) begin
                            trim_r[ch_r] <= sar_code_s;
                            if (sar_bit_r == '0) begin
                                sar_final_r <= 1'b1;
                            end else begin
                                sar_bit_r <= sar_bit_r - BIT_W'(1);
                            end
                            state_r <= ST_SETTLE;
                        end else begin
                            lock_r[ch_r] <= in_tol_s;
                            if (ch_r == CH_W'(N_CH - 1)) begin
                                done_r       <= 1'b1;
                                busy_r       <= 1'b0;
                                ch_r         <= '0;
                                track_mode_r <= track_en;
                                state_r      <= track_en ? ST_TRACK : ST_IDLE;
                            end else begin
                                ch_r              <= ch_next_s;
                                trim_r[ch_next_s] <= TRIM_MID;
                                sar_bit_r         <= BIT_W'(TRIM_W - 1);
                                sar_final_r       <= 1'b0;
                                state_r           <= ST_SETTLE;
                            end
                        end
                    end
                    default: begin
                        state_r <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign busy     = busy_r;
    assign done     = done_r;
    assign lock     = lock_r;
    assign meas_cnt = meas_cnt_r;
    assign meas_ch  = meas_ch_r;

endmodule

// File: tb/tb_relax_osc_trim_ctrl.sv
// Bench for relax_osc_trim_ctrl: oscillator model gives (2*code + offset) edges per
// model window; calibration results are queued at start and compared at done.
module tb_relax_osc_trim_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  osc = 2'b00;
    logic        start = 1'b0;
    logic        track_en = 1'b0;
    logic [11:0] target = 12'd0;
    logic [15:0] gate_len = 16'd100;
    logic [9:0]  trim;
    logic        busy, done;
    logic [1:0]  lock;
    logic [11:0] meas_cnt;
    logic        meas_ch;

    logic [1:0]  osc_sat = 2'b00;
    logic        start_sat = 1'b0;
    logic [3:0]  target_sat = 4'd15;
    logic [15:0] gate_len_sat = 16'd100;
    logic [9:0]  trim_sat;
    logic        busy_sat, done_sat;
    logic [1:0]  lock_sat;
    logic [3:0]  meas_cnt_sat;
    logic        meas_ch_sat;

    int tests_run = 0;
    int tests_failed = 0;
    int model_div = 100;
    int model_off = 10;
    int acc [2] = '{0, 0};
    int acc_sat = 0;

    typedef struct {
        int target;
        int gate;
        int div;
        int off;
        int exp_t0;
        int exp_t1;
        int exp_meas;
        int exp_lock;
        int cyc;
        bit full;
    } vec_t;

    vec_t tbl [6];
    vec_t sb [$];

    relax_osc_trim_ctrl u_dut (
        .clk(clk), .rst_n(rst_n), .osc_in(osc), .start(start), .track_en(track_en),
        .target(target), .gate_len(gate_len), .trim(trim), .busy(busy), .done(done),
        .lock(lock), .meas_cnt(meas_cnt), .meas_ch(meas_ch)
    );

    relax_osc_trim_ctrl #(.CNT_W(4)) u_sat (
        .clk(clk), .rst_n(rst_n), .osc_in(osc_sat), .start(start_sat), .track_en(1'b0),
        .target(target_sat), .gate_len(gate_len_sat), .trim(trim_sat), .busy(busy_sat),
        .done(done_sat), .lock(lock_sat), .meas_cnt(meas_cnt_sat), .meas_ch(meas_ch_sat)
    );

    always #5 clk = ~clk;

    // Oscillator model: phase accumulator yields exactly (2*code+off) pulses per model_div cycles.
    always @(negedge clk) begin
        for (int c = 0; c < 2; c++) begin
            acc[c] = acc[c] + 2 * int'(trim[c*5 +: 5]) + model_off;
            if (acc[c] >= model_div) begin
                acc[c] = acc[c] - model_div;
                osc[c] = 1'b1;
            end else begin
                osc[c] = 1'b0;
            end
        end
        acc_sat = acc_sat + 30;
        if (acc_sat >= 100) begin
            acc_sat = acc_sat - 100;
            osc_sat = 2'b11;
        end else begin
            osc_sat = 2'b00;
        end
    end

    function automatic int cal_len(input int g);
        return 1 + 2 * 6 * (8 + ((g == 0) ? 1 : g) + 1);
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        tests_run++;
        if (act != exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic run_entry(input int idx, input vec_t v);
        vec_t e;
        int   n;
        bit   got;
        int   mid;
        target    = 12'(v.target);
        gate_len  = 16'(v.gate);
        model_div = v.div;
        model_off = v.off;
        @(negedge clk);
        start = 1'b1;
        sb.push_back(v);
        @(negedge clk);
        start = 1'b0;
        n     = 1;
        got   = 1'b0;
        mid   = v.cyc / 2;
        check($sformatf("cal%0d_busy_rise", idx), busy, 1);
        check($sformatf("cal%0d_lock_clear", idx), lock, 0);
        while (!got && (n < v.cyc + 200)) begin
            if (done) begin
                got = 1'b1;
            end else begin
                start = (n == mid);
                @(negedge clk);
                n++;
            end
        end
        start = 1'b0;
        e = sb.pop_front();
        check($sformatf("cal%0d_done_seen", idx), got, 1);
        check($sformatf("cal%0d_cycles", idx), n, e.cyc);
        check($sformatf("cal%0d_busy_fall", idx), busy, 0);
        check($sformatf("cal%0d_meas_ch", idx), meas_ch, 1);
        if (e.full) begin
            check($sformatf("cal%0d_trim0", idx), trim[4:0], e.exp_t0);
            check($sformatf("cal%0d_trim1", idx), trim[9:5], e.exp_t1);
            check($sformatf("cal%0d_meas_cnt", idx), meas_cnt, e.exp_meas);
            check($sformatf("cal%0d_lock", idx), lock, e.exp_lock);
        end else begin
            check($sformatf("cal%0d_meas_le1", idx), (meas_cnt <= 12'd1), 1);
        end
        @(negedge clk);
        check($sformatf("cal%0d_done_pulse", idx), done, 0);
    endtask

    initial begin
        int   viol;
        int   n;
        int   dones;
        vec_t v;

        tbl[0] = '{41,  100, 100, 10, 15, 15, 40, 3, cal_len(100), 1'b1};
        tbl[1] = '{200, 200, 200, 10, 31, 31, 72, 0, cal_len(200), 1'b1};
        tbl[2] = '{30,  100, 100, 10, 10, 10, 30, 3, cal_len(100), 1'b1};
        tbl[3] = '{0,   100, 100, 10, 0,  0,  10, 0, cal_len(100), 1'b1};
        tbl[4] = '{11,  100, 100, 10, 0,  0,  10, 3, cal_len(100), 1'b1};
        tbl[5] = '{41,  0,   100, 10, 0,  0,  0,  0, cal_len(0),   1'b0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_trim", trim, 10'd528);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_lock", lock, 0);
        check("rst_meas_cnt", meas_cnt, 0);
        check("rst_meas_ch", meas_ch, 0);
        check("rst_sat_trim", trim_sat, 10'd528);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            run_entry(i, tbl[i]);
            repeat (5) @(negedge clk);
        end

        // Lock at code 15, then shift the oscillator up by 4 counts and let tracking pull it back.
        track_en = 1'b1;
        v = '{41, 100, 100, 10, 15, 15, 40, 3, cal_len(100), 1'b1};
        run_entry(10, v);
        model_off = 14;
        viol = 0;
        repeat (1500) begin
            @(negedge clk);
            if (busy !== 1'b0 || done !== 1'b0) viol++;
        end
        check("track_quiet", viol, 0);
        check("track_trim0", trim[4:0], 14);
        check("track_trim1", trim[9:5], 14);
        check("track_lock", lock, 3);
        check("track_meas_cnt", meas_cnt, 42);

        // Restart from tracking mode with the shifted oscillator.
        v = '{41, 100, 100, 14, 13, 13, 40, 3, cal_len(100), 1'b1};
        run_entry(11, v);
        dones = 0;
        repeat (400) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("retrack_no_extra_done", dones, 0);
        check("retrack_trim0", trim[4:0], 13);
        track_en = 1'b0;
        repeat (300) @(negedge clk);

        // Narrow counter: 30 edges per gate must saturate at 15.
        @(negedge clk);
        start_sat = 1'b1;
        @(negedge clk);
        start_sat = 1'b0;
        n = 1;
        while (!done_sat && (n < cal_len(100) + 200)) begin
            @(negedge clk);
            n++;
        end
        check("sat_done_seen", done_sat, 1);
        check("sat_cycles", n, cal_len(100));
        check("sat_meas_cnt", meas_cnt_sat, 15);
        check("sat_trim", trim_sat, 10'd1023);
        check("sat_lock", lock_sat, 3);
        repeat (5) @(negedge clk);

        // Asynchronous reset in the middle of a measurement window.
        target    = 12'd41;
        gate_len  = 16'd100;
        model_div = 100;
        model_off = 10;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (50) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_trim", trim, 10'd528);
        check("arst_busy", busy, 0);
        check("arst_lock", lock, 0);
        check("arst_done", done, 0);
        check("arst_meas_cnt", meas_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        viol = 0;
        repeat (300) begin
            @(negedge clk);
            if (busy !== 1'b0 || trim !== 10'd528) viol++;
        end
        check("arst_stays_idle", viol, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
